// File: rtl/alu_issue_ctrl.sv
// Issue/operand stage for the 8-bit combinational ALU: register file, EX register, writeback.
// Build option FORWARD_EN: forward the EX result on a RAW hazard instead of stalling for one cycle.
module alu_issue_ctrl #(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [DATA_W-1:0] in_imm,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_carry,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] OP_LDI = 4'd13;

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    logic              ex_vld_q, ex_vld_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] alu_x_q, alu_x_d;
    logic [DATA_W-1:0] alu_y_q, alu_y_d;

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_carry_q, wb_carry_d;

    logic              ex_is_ldi;
    logic [DATA_W-1:0] ex_result;
    logic              ex_carry;
    logic              hit_x, hit_y;
    logic [DATA_W-1:0] opnd_x, opnd_y;
    logic              accept;

    // EX result as it will land in the register file at the coming edge
    always_comb begin
        ex_is_ldi = (alu_ctrl_q == OP_LDI);
        ex_result = ex_is_ldi ? alu_x_q : alu_out;
        ex_carry  = ex_is_ldi ? 1'b0 : alu_carry;
        hit_x     = ex_vld_q && (in_rs == ex_rd_q);
        hit_y     = ex_vld_q && (in_rt == ex_rd_q);
    end

`ifdef FORWARD_EN
    always_comb begin
        in_ready = rst_n;
        opnd_x   = hit_x ? ex_result : regs_q[in_rs];
        opnd_y   = hit_y ? ex_result : regs_q[in_rt];
    end
`else
    // Holding the instruction for one cycle lets the pending write reach the register file
    always_comb begin
        in_ready = rst_n && !(in_valid && (hit_x || hit_y));
        opnd_x   = regs_q[in_rs];
        opnd_y   = regs_q[in_rt];
    end
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        regs_d = regs_q;
        if (ex_vld_q) begin
            regs_d[ex_rd_q] = ex_result;
        end

        ex_vld_d   = accept;
        ex_rd_d    = ex_rd_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        if (accept) begin
            ex_rd_d    = in_rd;
            alu_ctrl_d = in_ctrl;
            alu_x_d    = (in_ctrl == OP_LDI) ? in_imm : opnd_x;
            alu_y_d    = (in_ctrl == OP_LDI) ? '0 : opnd_y;
        end

        // wb_carry doubles as the sticky carry flag, so it only changes on a retire
        wb_valid_d = ex_vld_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_carry_d = wb_carry_q;
        if (ex_vld_q) begin
            wb_rd_d    = ex_rd_q;
            wb_data_d  = ex_result;
            wb_carry_d = ex_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            ex_vld_q   <= 1'b0;
            ex_rd_q    <= '0;
            alu_ctrl_q <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_carry_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ex_vld_q   <= ex_vld_d;
            ex_rd_q    <= ex_rd_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_carry_q <= wb_carry_d;
        end
    end

    assign alu_ctrl = alu_ctrl_q;
    assign alu_x    = alu_x_q;
    assign alu_y    = alu_y_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_carry = wb_carry_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural model of the downstream ALU.
// Timing expectations follow the FORWARD_EN build option.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_ctrl;
    logic [ADDR_W-1:0] in_rd, in_rs, in_rt;
    logic [DATA_W-1:0] in_imm;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_x, alu_y, alu_out;
    logic              alu_carry;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_carry;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    alu_issue_ctrl #(.DATA_W(DATA_W), .REG_NUM(8), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU model for the opcodes exercised here: ADD, ROTL by one, EQ
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_ctrl)
            4'd0:    {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            4'd10:   alu_out = {alu_x[6:0], alu_x[7]};
            4'd12:   alu_out = (alu_x == alu_y) ? 8'd1 : 8'd0;
            default: alu_out = '0;
        endcase
    end

    typedef logic [ADDR_W+DATA_W:0] exp_t;
    exp_t sb[$];
    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int wb_cnt = 0;
    int last_wb = -1;
    int prev_wb = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every retire must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            exp_t e;
            wb_cnt++;
            prev_wb = last_wb;
            last_wb = cyc;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no writeback", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                chk("wb_rd",    32'(wb_rd),    32'(e[ADDR_W+DATA_W:DATA_W+1]));
                chk("wb_data",  32'(wb_data),  32'(e[DATA_W:1]));
                chk("wb_carry", 32'(wb_carry), 32'(e[0]));
            end
        end
    end

    task automatic issue(input logic [3:0] ctrl, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] exp_data,
                         input logic exp_c, input bit push, output int stalls);
        @(negedge clk);
        in_valid = 1'b1; in_ctrl = ctrl; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
        stalls = 0;
        #1;
        while (in_ready !== 1'b1 && stalls < 8) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            $display("FAIL issue_timeout: got in_ready=%b after %0d cycles, expected 1", in_ready, stalls);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) sb.push_back({rd, exp_data, exp_c});
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic ldi(input logic [2:0] rd, input logic [7:0] imm, input bit push);
        int st;
        issue(4'd13, rd, 3'd0, 3'd0, imm, imm, 1'b0, push, st);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic dbg_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = a;
        #1 chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int st;
        int wb_before;
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        in_imm = '0; dbg_addr = '0;

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1 chk("rst_dbg", 32'(dbg_data), 32'd0);
        end
        rst_n = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // T2 add
        ldi(3'd1, 8'h7F, 1'b1);
        ldi(3'd2, 8'h01, 1'b1);
        issue(4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 1'b0, 1'b1, st);
        drain();
        dbg_chk("t2_dbg_r3", 3'd3, 8'h80);

        // T3 carry, then the flag must hold while idle
        ldi(3'd1, 8'h80, 1'b1);
        issue(4'd0, 3'd2, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b1, st);
        drain();
        chk("t3_carry_sticky", 32'(wb_carry), 32'd1);

        // T4 back-to-back hazard
        ldi(3'd1, 8'h05, 1'b1);
        issue(4'd0, 3'd2, 3'd1, 3'd1, 8'h00, 8'h0A, 1'b0, 1'b1, st);
        drain();
`ifdef FORWARD_EN
        chk("t4_stall_cycles", 32'(st), 32'd0);
        chk("t4_retire_gap", 32'(last_wb - prev_wb), 32'd1);
`else
        chk("t4_stall_cycles", 32'(st), 32'd1);
        chk("t4_retire_gap", 32'(last_wb - prev_wb), 32'd2);
`endif
        dbg_chk("t4_dbg_r2", 3'd2, 8'h0A);

        // T5 rotate then equality, both depending on the previous result
        ldi(3'd4, 8'h81, 1'b1);
        issue(4'd10, 3'd5, 3'd4, 3'd0, 8'h00, 8'h03, 1'b0, 1'b1, st);
        issue(4'd12, 3'd6, 3'd5, 3'd5, 8'h00, 8'h01, 1'b0, 1'b1, st);
        drain();
        dbg_chk("t5_dbg_r5", 3'd5, 8'h03);

        // T6 reset while an LDI sits in EX
        wb_before = wb_cnt;
        ldi(3'd7, 8'hAA, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        chk("t6_no_wb", 32'(wb_cnt), 32'(wb_before));
        dbg_chk("t6_dbg_r7", 3'd7, 8'h00);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
